mmu_feeder: RTL and testbench

- Operand store and skew feeder between the control unit and the 2x2 systolic MMU.
- Captures the 8 host-supplied elements (4 of matrix A, 4 of weight matrix B) under control-unit write strobes.
- During the feed phase, drives the MMU left edge (A rows) and top edge (B columns) with the diagonal skew an output-stationary 2x2 array needs, plus valid and clear strobes.

---
 rtl/tpu_pkg.sv | 33 +++
 rtl/mmu_operand_store.sv | 84 ++++++++
 rtl/mmu_feeder.sv | 140 ++++++++++++++
 tb/tb_mmu_feeder.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath blocks.
//   DATA_W       : width of one matrix element / feed operand
//   N            : systolic array dimension (the feeder is built for 2)
//   NUM_ELEMS    : operand store depth (4 A elements + 4 B elements)
//   FEED_STEPS   : number of feed_cycle steps, the last one being the drain step
//   ADDR_*       : store addresses, A then B, both row-major
package tpu_pkg;

    localparam int DATA_W     = 8;
    localparam int N          = 2;
    localparam int NUM_ELEMS  = 8;
    localparam int FEED_STEPS = 4;

    typedef logic [2:0] addr_t;

    localparam addr_t ADDR_A00 = 3'd0;
    localparam addr_t ADDR_A01 = 3'd1;
    localparam addr_t ADDR_A10 = 3'd2;
    localparam addr_t ADDR_A11 = 3'd3;
    localparam addr_t ADDR_B00 = 3'd4;
    localparam addr_t ADDR_B01 = 3'd5;
    localparam addr_t ADDR_B10 = 3'd6;
    localparam addr_t ADDR_B11 = 3'd7;

    // Feed steps as presented on feed_cycle; STEP_DRAIN carries no data.
    typedef enum logic [1:0] {
        STEP_0     = 2'd0,
        STEP_1     = 2'd1,
        STEP_2     = 2'd2,
        STEP_DRAIN = 2'd3
    } feed_step_e;

endpackage

// File: rtl/mmu_operand_store.sv
// Operand store for the 2x2 MMU feeder.
// Holds the 8 matrix elements, the bitmap of addresses written since the
// last clear, the registered mats_ready flag and the sticky load_err flag.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   wm_load_mat     : write strobe
//   wm_addr         : element address (tpu_pkg ADDR_*)
//   load_data       : element value
//   feeding_active  : feed phase in progress; writes are refused while high
//   bitmap_clr      : clear the written-bitmap (end of a feed)
//   mem_o           : all stored elements, indexed by address
//   mats_ready      : every address written since the last clear
//   load_err        : sticky, a write was attempted during a feed
module mmu_operand_store
    import tpu_pkg::*;
#(
    parameter int ELEM_W = tpu_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wm_load_mat,
    input  logic [2:0]        wm_addr,
    input  logic [ELEM_W-1:0] load_data,
    input  logic              feeding_active,
    input  logic              bitmap_clr,
    output logic [ELEM_W-1:0] mem_o [NUM_ELEMS],
    output logic              mats_ready,
    output logic              load_err
);

    logic [ELEM_W-1:0]    mem_q [NUM_ELEMS];
    logic [ELEM_W-1:0]    mem_d [NUM_ELEMS];
    logic [NUM_ELEMS-1:0] written_q;
    logic [NUM_ELEMS-1:0] written_d;
    logic                 mats_ready_q;
    logic                 mats_ready_d;
    logic                 load_err_q;
    logic                 load_err_d;
    logic                 wr_ok;

    assign wr_ok = wm_load_mat & ~feeding_active;

    // A write landing on the same edge as the bitmap clear still marks its
    // address, so the first element of the next job is not lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_ELEMS; gi++) begin : g_elem
            logic we;
            assign we            = wr_ok && (wm_addr == 3'(gi));
            assign mem_d[gi]     = we ? load_data : mem_q[gi];
            assign written_d[gi] = we | (written_q[gi] & ~bitmap_clr);
            assign mem_o[gi]     = mem_q[gi];
        end
    endgenerate

    // Derived from the next bitmap so the flag rises right after the
    // edge that captures the last missing address.
    always_comb begin
        mats_ready_d = &written_d;
        load_err_d   = load_err_q | (wm_load_mat & feeding_active);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                mem_q[i] <= '0;
            end
            written_q    <= '0;
            mats_ready_q <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ELEMS; i++) begin
                mem_q[i] <= mem_d[i];
            end
            written_q    <= written_d;
            mats_ready_q <= mats_ready_d;
            load_err_q   <= load_err_d;
        end
    end

    assign mats_ready = mats_ready_q;
    assign load_err   = load_err_q;

endmodule

// File: rtl/mmu_feeder.sv
// Operand store and diagonal-skew feeder for the 2x2 output-stationary MMU.
// Host elements are captured into mmu_operand_store; during the feed phase
// feed_cycle selects which stored elements drive the array's left edge
// (a_row*) and top edge (b_col*), registered with one cycle of latency.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   wm_load_mat, wm_addr,
//   load_data             : element write interface from the control unit
//   feeding_active        : feed phase active
//   feed_cycle            : feed step 0..3 (3 = drain)
//   a_row0, a_row1        : left-edge operands for MMU rows 0/1
//   b_col0, b_col1        : top-edge operands for MMU columns 0/1
//   feed_valid            : edge operands valid
//   mmu_clear             : one-cycle accumulator clear at feed start
//   mats_ready            : all 8 elements written since the last feed
//   load_err              : sticky, write attempted during a feed
module mmu_feeder
    import tpu_pkg::*;
#(
    parameter int DATA_W = tpu_pkg::DATA_W,
    parameter int N      = tpu_pkg::N
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wm_load_mat,
    input  logic [2:0]        wm_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              feeding_active,
    input  logic [1:0]        feed_cycle,
    output logic [DATA_W-1:0] a_row0,
    output logic [DATA_W-1:0] a_row1,
    output logic [DATA_W-1:0] b_col0,
    output logic [DATA_W-1:0] b_col1,
    output logic              feed_valid,
    output logic              mmu_clear,
    output logic              mats_ready,
    output logic              load_err
);

    generate
        if (N != 2) begin : g_bad_n
            $error("mmu_feeder: only N=2 is supported");
        end
    endgenerate

    logic [DATA_W-1:0] mem [NUM_ELEMS];
    logic              feed_act_q;
    logic              bitmap_clr;

    logic [DATA_W-1:0] a_row0_q, a_row0_d;
    logic [DATA_W-1:0] a_row1_q, a_row1_d;
    logic [DATA_W-1:0] b_col0_q, b_col0_d;
    logic [DATA_W-1:0] b_col1_q, b_col1_d;
    logic              feed_valid_q, feed_valid_d;
    logic              mmu_clear_q, mmu_clear_d;

    // Falling edge of feeding_active ends a job: the next job must reload.
    assign bitmap_clr = feed_act_q & ~feeding_active;

    mmu_operand_store #(
        .ELEM_W (DATA_W)
    ) u_store (
        .clk            (clk),
        .rst_n          (rst_n),
        .wm_load_mat    (wm_load_mat),
        .wm_addr        (wm_addr),
        .load_data      (load_data),
        .feeding_active (feeding_active),
        .bitmap_clr     (bitmap_clr),
        .mem_o          (mem),
        .mats_ready     (mats_ready),
        .load_err       (load_err)
    );

    // Skew: row/column k enters the array k cycles late, with literal zeros
    // filling the slots before and after each operand stream.
    always_comb begin
        a_row0_d     = '0;
        a_row1_d     = '0;
        b_col0_d     = '0;
        b_col1_d     = '0;
        feed_valid_d = 1'b0;
        mmu_clear_d  = feeding_active & ~feed_act_q;
        if (feeding_active) begin
            unique case (feed_step_e'(feed_cycle))
                STEP_0: begin
                    a_row0_d     = mem[ADDR_A00];
                    b_col0_d     = mem[ADDR_B00];
                    feed_valid_d = 1'b1;
                end
                STEP_1: begin
                    a_row0_d     = mem[ADDR_A01];
                    a_row1_d     = mem[ADDR_A10];
                    b_col0_d     = mem[ADDR_B10];
                    b_col1_d     = mem[ADDR_B01];
                    feed_valid_d = 1'b1;
                end
                STEP_2: begin
                    a_row1_d     = mem[ADDR_A11];
                    b_col1_d     = mem[ADDR_B11];
                    feed_valid_d = 1'b1;
                end
                STEP_DRAIN: begin
                    feed_valid_d = 1'b0;
                end
                default: begin
                    feed_valid_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feed_act_q   <= 1'b0;
            a_row0_q     <= '0;
            a_row1_q     <= '0;
            b_col0_q     <= '0;
            b_col1_q     <= '0;
            feed_valid_q <= 1'b0;
            mmu_clear_q  <= 1'b0;
        end else begin
            feed_act_q   <= feeding_active;
            a_row0_q     <= a_row0_d;
            a_row1_q     <= a_row1_d;
            b_col0_q     <= b_col0_d;
            b_col1_q     <= b_col1_d;
            feed_valid_q <= feed_valid_d;
            mmu_clear_q  <= mmu_clear_d;
        end
    end

    assign a_row0     = a_row0_q;
    assign a_row1     = a_row1_q;
    assign b_col0     = b_col0_q;
    assign b_col1     = b_col1_q;
    assign feed_valid = feed_valid_q;
    assign mmu_clear  = mmu_clear_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Scoreboard bench for mmu_feeder: the stimulus pushes the expected edge
// outputs for each driven cycle; a negedge monitor pops and compares them.
module tb_mmu_feeder;

    logic       clk;
    logic       rst_n;
    logic       wm_load_mat;
    logic [2:0] wm_addr;
    logic [7:0] load_data;
    logic       feeding_active;
    logic [1:0] feed_cycle;
    logic [7:0] a_row0, a_row1, b_col0, b_col1;
    logic       feed_valid, mmu_clear, mats_ready, load_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int          due;
        string       name;
        logic [33:0] v;   // {a0,a1,b0,b1,valid,clear}
    } exp_t;

    exp_t sb[$];

    mmu_feeder #(.DATA_W(8), .N(2)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .wm_load_mat    (wm_load_mat),
        .wm_addr        (wm_addr),
        .load_data      (load_data),
        .feeding_active (feeding_active),
        .feed_cycle     (feed_cycle),
        .a_row0         (a_row0),
        .a_row1         (a_row1),
        .b_col0         (b_col0),
        .b_col1         (b_col1),
        .feed_valid     (feed_valid),
        .mmu_clear      (mmu_clear),
        .mats_ready     (mats_ready),
        .load_err       (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [33:0] outs();
        return {a_row0, a_row1, b_col0, b_col1, feed_valid, mmu_clear};
    endfunction

    // Monitor: compares every expectation that falls due this cycle.
    always @(negedge clk) begin : monitor
        exp_t e;
        logic [33:0] act;
        if (rst_n) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                e   = sb.pop_front();
                act = outs();
                checks++;
                if (e.due != cyc) begin
                    errors++;
                    $display("FAIL %s: not checked in its cycle (due %0d, now %0d)", e.name, e.due, cyc);
                end else if (act !== e.v) begin
                    errors++;
                    $display("FAIL %s: got a0=%0d a1=%0d b0=%0d b1=%0d v=%0b clr=%0b, want a0=%0d a1=%0d b0=%0d b1=%0d v=%0b clr=%0b",
                             e.name, act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0],
                             e.v[33:26], e.v[25:18], e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
                end else begin
                    $display("ok   %s: a0=%0d a1=%0d b0=%0d b1=%0d v=%0b clr=%0b",
                             e.name, act[33:26], act[25:18], act[17:10], act[9:2], act[1], act[0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end else begin
            $display("ok   %s: 0x%0h", nm, act);
        end
    endtask

    task automatic write(input logic [2:0] addr, input logic [7:0] data);
        wm_load_mat = 1'b1;
        wm_addr     = addr;
        load_data   = data;
        tick();
        wm_load_mat = 1'b0;
    endtask

    task automatic feed(input logic [1:0] t, input logic [7:0] a0, input logic [7:0] a1,
                        input logic [7:0] b0, input logic [7:0] b1,
                        input logic v, input logic clr, input string nm);
        exp_t e;
        feeding_active = 1'b1;
        feed_cycle     = t;
        e.due  = cyc + 1;
        e.name = nm;
        e.v    = {a0, a1, b0, b1, v, clr};
        sb.push_back(e);
        tick();
    endtask

    task automatic idle(input string nm);
        exp_t e;
        feeding_active = 1'b0;
        feed_cycle     = 2'd0;
        e.due  = cyc + 1;
        e.name = nm;
        e.v    = '0;
        sb.push_back(e);
        tick();
    endtask

    task automatic load8(input logic [7:0] base, input string nm);
        for (int i = 0; i < 8; i++) begin
            write(3'(i), base + 8'(i));
            if (i == 6) chk({nm, "_ready_after7"}, 34'(mats_ready), 34'd0);
            if (i == 7) chk({nm, "_ready_after8"}, 34'(mats_ready), 34'd1);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst_n          = 1'b0;
        wm_load_mat    = 1'b0;
        wm_addr        = '0;
        load_data      = '0;
        feeding_active = 1'b0;
        feed_cycle     = '0;
        #3;
        chk("reset_outputs", {outs()}, 34'd0);
        tick();
        tick();
        chk("reset_flags", 34'({mats_ready, load_err}), 34'd0);
        rst_n = 1'b1;
        tick();

        // Job 1: A=[1,2;3,4], B=[5,6;7,8]
        load8(8'd1, "job1");
        feed(2'd0, 8'd1, 8'd0, 8'd5, 8'd0, 1'b1, 1'b1, "job1_t0");
        // write attempted during the feed must be refused
        wm_load_mat = 1'b1; wm_addr = 3'd0; load_data = 8'hFF;
        feed(2'd1, 8'd2, 8'd3, 8'd7, 8'd6, 1'b1, 1'b0, "job1_t1");
        wm_load_mat = 1'b0;
        chk("load_err_set", 34'(load_err), 34'd1);
        feed(2'd2, 8'd0, 8'd4, 8'd0, 8'd8, 1'b1, 1'b0, "job1_t2");
        feed(2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "job1_t3");
        chk("ready_during_feed", 34'(mats_ready), 34'd1);
        idle("job1_idle");
        chk("ready_cleared", 34'(mats_ready), 34'd0);
        chk("load_err_sticky", 34'(load_err), 34'd1);

        // Feed again without reload: stored values retained, A00 still 1
        feed(2'd0, 8'd1, 8'd0, 8'd5, 8'd0, 1'b1, 1'b1, "refeed_t0");
        feed(2'd1, 8'd2, 8'd3, 8'd7, 8'd6, 1'b1, 1'b0, "refeed_t1");
        feed(2'd2, 8'd0, 8'd4, 8'd0, 8'd8, 1'b1, 1'b0, "refeed_t2");
        feed(2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "refeed_t3");
        idle("refeed_idle");

        // Job 2 back-to-back: A=[10,11;12,13], B=[14,15;16,17], then A11 <- 9
        load8(8'd10, "job2");
        write(3'd3, 8'd9);
        chk("job2_ready_after_rewrite", 34'(mats_ready), 34'd1);
        feed(2'd0, 8'd10, 8'd0,  8'd14, 8'd0,  1'b1, 1'b1, "job2_t0");
        feed(2'd1, 8'd11, 8'd12, 8'd16, 8'd15, 1'b1, 1'b0, "job2_t1");
        feed(2'd2, 8'd0,  8'd9,  8'd0,  8'd17, 1'b1, 1'b0, "job2_t2");
        feed(2'd3, 8'd0,  8'd0,  8'd0,  8'd0,  1'b0, 1'b0, "job2_t3");
        idle("job2_idle");

        // Asynchronous reset in the middle of a feed
        feed(2'd0, 8'd10, 8'd0, 8'd14, 8'd0, 1'b1, 1'b1, "rst_t0");
        @(negedge clk);
        #1;
        feed_cycle = 2'd1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", outs(), 34'd0);
        chk("async_reset_flags", 34'({mats_ready, load_err}), 34'd0);
        sb.delete();
        feeding_active = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // After reset the store is empty: zeros fed with normal valid/clear
        feed(2'd0, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1, "post_rst_t0");
        feed(2'd1, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, "post_rst_t1");
        feed(2'd2, 8'd0, 8'd0, 8'd0, 8'd0, 1'b1, 1'b0, "post_rst_t2");
        feed(2'd3, 8'd0, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0, "post_rst_t3");
        idle("post_rst_idle");

        for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: %0d expectations left, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
